// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Bridges RV32I loads and stores from the EX/MEM stage onto a word-addressed
//   data memory that only reads and writes whole 32-bit words.
//   - Byte and halfword loads pick a lane and sign- or zero-extend it.
//   - Byte and halfword stores read the word, merge the new lane, then write.
//   - Misaligned or unsupported requests get an error response and never
//     reach memory.
//   Optional build macro: LSU_RANGE_CHECK_EN
//     When defined, a word address at or above MEM_WORDS is illegal.
//     When undefined, the address passes through and memory aliasing applies.
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  // pipeline request side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_load,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  // pipeline response side
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  // data memory side
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  // RV32I width/sign encodings in funct3
  localparam logic [2:0] LP_F3_B  = 3'b000;
  localparam logic [2:0] LP_F3_H  = 3'b001;
  localparam logic [2:0] LP_F3_W  = 3'b010;
  localparam logic [2:0] LP_F3_BU = 3'b100;
  localparam logic [2:0] LP_F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RMW_READ = 3'd2,
    S_WRITE    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Alignment and opcode legality of a request (range check handled apart).
  function automatic logic f_is_legal(input logic       is_load,
                                      input logic [2:0] f3,
                                      input logic [1:0] lane);
    logic v_ok;
    case (f3)
      LP_F3_B:  v_ok = 1'b1;
      LP_F3_H:  v_ok = ~lane[0];
      LP_F3_W:  v_ok = (lane == 2'b00);
      LP_F3_BU: v_ok = is_load;
      LP_F3_HU: v_ok = is_load & ~lane[0];
      default:  v_ok = 1'b0;
    endcase
    return v_ok;
  endfunction

  // Select the addressed byte/half of a memory word and extend it to 32 bits.
  function automatic logic [31:0] f_load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
    logic [7:0]  v_byte;
    logic [15:0] v_half;
    logic [31:0] v_out;
    case (lane)
      2'b00:   v_byte = word[7:0];
      2'b01:   v_byte = word[15:8];
      2'b10:   v_byte = word[23:16];
      default: v_byte = word[31:24];
    endcase
    v_half = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      LP_F3_B:  v_out = {{24{v_byte[7]}}, v_byte};
      LP_F3_BU: v_out = {24'h000000, v_byte};
      LP_F3_H:  v_out = {{16{v_half[15]}}, v_half};
      LP_F3_HU: v_out = {16'h0000, v_half};
      LP_F3_W:  v_out = word;
      default:  v_out = 32'h0000_0000;
    endcase
    return v_out;
  endfunction

  // Replace the addressed byte/half lane of the old word with store data.
  function automatic logic [31:0] f_store_merge(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] old_word,
                                                input logic [31:0] wdata);
    logic [31:0] v_word;
    v_word = old_word;
    case (f3)
      LP_F3_B: begin
        case (lane)
          2'b00:   v_word[7:0]   = wdata[7:0];
          2'b01:   v_word[15:8]  = wdata[7:0];
          2'b10:   v_word[23:16] = wdata[7:0];
          default: v_word[31:24] = wdata[7:0];
        endcase
      end
      LP_F3_H: begin
        if (lane[1]) begin
          v_word[31:16] = wdata[15:0];
        end else begin
          v_word[15:0]  = wdata[15:0];
        end
      end
      default: v_word = wdata;
    endcase
    return v_word;
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic [31:0] r_mem_address;
  logic [31:0] r_mem_write_data;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  logic        w_accept;
  logic        w_range_ok;
  logic        w_legal;

  assign w_accept = req_valid && (r_state == S_IDLE);

`ifdef LSU_RANGE_CHECK_EN
  // Word index must fall inside the physical memory.
  assign w_range_ok = (req_addr[31:2] < 30'(MEM_WORDS));
`else
  // Out-of-range addresses alias inside the memory; nothing to reject.
  assign w_range_ok = 1'b1;
`endif

  assign w_legal = w_range_ok &&
                   f_is_legal(req_is_load, req_funct3, req_addr[1:0]);

  // State register; async reset aborts any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode for the access sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_accept) begin
          w_next_state = S_IDLE;
        end else if (!w_legal) begin
          w_next_state = S_DONE;
        end else if (req_is_load) begin
          w_next_state = S_LOAD;
        end else if (req_funct3 == LP_F3_W) begin
          w_next_state = S_WRITE;
        end else begin
          w_next_state = S_RMW_READ;
        end
      end
      S_LOAD:     w_next_state = S_DONE;
      S_RMW_READ: w_next_state = S_WRITE;
      S_WRITE:    w_next_state = S_DONE;
      S_DONE:     w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Request capture, load-data extension and read-modify-write merge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3         <= 3'b000;
      r_lane           <= 2'b00;
      r_wdata          <= 32'h0000_0000;
      r_mem_address    <= 32'h0000_0000;
      r_mem_write_data <= 32'h0000_0000;
      r_resp_err       <= 1'b0;
      r_resp_rdata     <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_funct3     <= req_funct3;
            r_lane       <= req_addr[1:0];
            r_wdata      <= req_wdata;
            r_resp_err   <= ~w_legal;
            r_resp_rdata <= 32'h0000_0000;
            // Illegal requests leave the memory-side registers untouched.
            if (w_legal) begin
              r_mem_address    <= {req_addr[31:2], 2'b00};
              r_mem_write_data <= req_wdata;
            end
          end
        end
        S_LOAD: begin
          r_resp_rdata <= f_load_extend(r_funct3, r_lane, mem_read_data);
        end
        S_RMW_READ: begin
          r_mem_write_data <= f_store_merge(r_funct3, r_lane,
                                            mem_read_data, r_wdata);
        end
        default: begin
          r_resp_rdata <= r_resp_rdata;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: strobes are decoded straight from the state register so that an
  // asynchronous reset removes them in the same instant.
  // ---------------------------------------------------------------------------
  assign req_ready      = (r_state == S_IDLE);
  assign resp_valid     = (r_state == S_DONE);
  assign mem_read       = (r_state == S_LOAD) || (r_state == S_RMW_READ);
  assign mem_write      = (r_state == S_WRITE);
  assign resp_err       = r_resp_err;
  assign resp_rdata     = r_resp_rdata;
  assign mem_address    = r_mem_address;
  assign mem_write_data = r_mem_write_data;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed, table-driven bench for load_store_unit with a 1024-word
//   behavioural data memory (combinational read, write at posedge).
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_load;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_idx  = 0;

  logic [31:0] tb_mem [0:1023];

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_load    (req_is_load),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_err       (resp_err),
    .resp_rdata     (resp_rdata),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: word index wraps on the low address bits.
  assign mem_read_data = tb_mem[mem_address[11:2]];

  always @(posedge clk) begin
    if (mem_write) tb_mem[mem_address[11:2]] <= mem_write_data;
  end

  typedef struct {
    logic        is_load;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          reads;
    int          writes;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [vec %0d]: got 0x%08h, expected 0x%08h",
               name, cur_idx, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v);
    int   lat;
    int   reads;
    int   writes;
    bit   got;
    bit   mem_ok;
    logic [31:0] exp_addr;
    exp_addr = {v.addr[31:2], 2'b00};
    @(negedge clk);
    check("ready_before", {31'd0, req_ready}, 32'd1);
    req_valid   = 1'b1;
    req_is_load = v.is_load;
    req_funct3  = v.f3;
    req_addr    = v.addr;
    req_wdata   = v.wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1; reads = 0; writes = 0; got = 1'b0; mem_ok = 1'b1;
    while (!got && lat <= 8) begin
      if (req_ready) mem_ok = 1'b0;
      if (mem_read && mem_write) mem_ok = 1'b0;
      if (resp_valid) begin
        got = 1'b1;
        if (mem_read || mem_write) mem_ok = 1'b0;
      end else begin
        if (mem_read)  reads++;
        if (mem_write) writes++;
        if ((mem_read || mem_write) && (mem_address !== exp_addr)) mem_ok = 1'b0;
        @(posedge clk);
        #1;
        lat++;
      end
    end
    check("resp_seen", {31'd0, got}, 32'd1);
    check("latency", lat, v.lat);
    check("resp_err", {31'd0, resp_err}, {31'd0, v.err});
    check("resp_rdata", resp_rdata, v.rdata);
    check("mem_reads", reads, v.reads);
    check("mem_writes", writes, v.writes);
    check("mem_side_ok", {31'd0, mem_ok}, 32'd1);
    @(posedge clk);
    #1;
    check("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    check("ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
    check({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
    check({tag, "_mem_address"}, mem_address, 32'd0);
    check({tag, "_mem_wdata"}, mem_write_data, 32'd0);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  vec_t rv;

  initial begin
    for (int i = 0; i < 1024; i++) tb_mem[i] = 32'h0000_0000;

    //           ld    f3      addr           wdata          err   rdata         lat r w
    vecs[0]  = '{1'b0, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 2, 0, 1};
    vecs[1]  = '{1'b1, 3'b000, 32'h0000_0013, 32'h0,         1'b0, 32'hFFFF_FFDE, 2, 1, 0};
    vecs[2]  = '{1'b1, 3'b100, 32'h0000_0013, 32'h0,         1'b0, 32'h0000_00DE, 2, 1, 0};
    vecs[3]  = '{1'b1, 3'b001, 32'h0000_0010, 32'h0,         1'b0, 32'hFFFF_BEEF, 2, 1, 0};
    vecs[4]  = '{1'b1, 3'b101, 32'h0000_0012, 32'h0,         1'b0, 32'h0000_DEAD, 2, 1, 0};
    vecs[5]  = '{1'b1, 3'b010, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 2, 1, 0};
    vecs[6]  = '{1'b0, 3'b000, 32'h0000_0011, 32'h0000_0055, 1'b0, 32'h0000_0000, 3, 1, 1};
    vecs[7]  = '{1'b1, 3'b010, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_55EF, 2, 1, 0};
    vecs[8]  = '{1'b1, 3'b010, 32'h0000_0012, 32'h0,         1'b1, 32'h0000_0000, 1, 0, 0};
    vecs[9]  = '{1'b1, 3'b001, 32'h0000_0011, 32'h0,         1'b1, 32'h0000_0000, 1, 0, 0};
    vecs[10] = '{1'b0, 3'b100, 32'h0000_0010, 32'h1111_1111, 1'b1, 32'h0000_0000, 1, 0, 0};
    vecs[11] = '{1'b0, 3'b001, 32'h0000_0016, 32'h1234_8001, 1'b0, 32'h0000_0000, 3, 1, 1};
    vecs[12] = '{1'b1, 3'b001, 32'h0000_0016, 32'h0,         1'b0, 32'hFFFF_8001, 2, 1, 0};
    vecs[13] = '{1'b1, 3'b101, 32'h0000_0016, 32'h0,         1'b0, 32'h0000_8001, 2, 1, 0};
    vecs[14] = '{1'b1, 3'b000, 32'h0000_0017, 32'h0,         1'b0, 32'hFFFF_FF80, 2, 1, 0};
    vecs[15] = '{1'b1, 3'b011, 32'h0000_0018, 32'h0,         1'b1, 32'h0000_0000, 1, 0, 0};
    vecs[16] = '{1'b0, 3'b011, 32'h0000_0018, 32'h2222_2222, 1'b1, 32'h0000_0000, 1, 0, 0};
    vecs[17] = '{1'b1, 3'b110, 32'h0000_0018, 32'h0,         1'b1, 32'h0000_0000, 1, 0, 0};
    vecs[18] = '{1'b0, 3'b000, 32'h0000_0014, 32'h0000_00AB, 1'b0, 32'h0000_0000, 3, 1, 1};
    vecs[19] = '{1'b1, 3'b010, 32'h0000_0014, 32'h0,         1'b0, 32'h8001_00AB, 2, 1, 0};
    vecs[20] = '{1'b1, 3'b000, 32'h0000_0014, 32'h0,         1'b0, 32'hFFFF_FFAB, 2, 1, 0};
    vecs[21] = '{1'b1, 3'b100, 32'h0000_0015, 32'h0,         1'b0, 32'h0000_0000, 2, 1, 0};

    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_is_load = 1'b0;
    req_funct3  = 3'b000;
    req_addr    = 32'h0;
    req_wdata   = 32'h0;

    // Reset state, during and after reset.
    repeat (2) @(posedge clk);
    #1;
    cur_idx = -1;
    check_idle_outputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("post_reset");

    // Main directed table.
    for (int i = 0; i < 22; i++) begin
      cur_idx = i;
      run_req(vecs[i]);
    end
    check("mem_word_0x10", tb_mem[4], 32'hDEAD_55EF);
    check("mem_word_0x14", tb_mem[5], 32'h8001_00AB);

    // Out-of-range load (range check optional).
    cur_idx = 100;
`ifdef LSU_RANGE_CHECK_EN
    rv = '{1'b1, 3'b010, 32'h0000_1000, 32'h0, 1'b1, 32'h0000_0000, 1, 0, 0};
`else
    rv = '{1'b1, 3'b010, 32'h0000_1000, 32'h0, 1'b0, 32'h0000_0000, 2, 1, 0};
`endif
    run_req(rv);

    // SH aborted by reset during its WRITE cycle.
    cur_idx = 200;
    @(negedge clk);
    req_valid   = 1'b1;
    req_is_load = 1'b0;
    req_funct3  = 3'b001;
    req_addr    = 32'h0000_0020;
    req_wdata   = 32'h0000_BEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("abort_rmw_read", {31'd0, mem_read}, 32'd1);
    @(posedge clk);
    #1;
    check("abort_write_phase", {31'd0, mem_write}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_write_drop", {31'd0, mem_write}, 32'd0);
    check("abort_read_drop", {31'd0, mem_read}, 32'd0);
    check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("abort_no_late_resp", {31'd0, resp_valid}, 32'd0);
    end
    check("abort_mem_untouched", tb_mem[8], 32'h0000_0000);
    cur_idx = 201;
    rv = '{1'b1, 3'b010, 32'h0000_0020, 32'h0, 1'b0, 32'h0000_0000, 2, 1, 0};
    run_req(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
